sprite_scheduler: RTL and testbench
===================================

# sprite_scheduler

Frame-level controller for the game's player sprite. On each frame tick from the rate limiter it reads the move buttons and updates the player x position. It then drives the VGA adapter write port (x, y, colour, plot) to erase the sprite at its old position and redraw it at the new one. It sits between `limiter` and `vga_adapter` and replaces free-running per-pixel scanning with sequenced rectangle fills.

## Interface
- SCREEN_W, 160: visible width in pixels
- SCREEN_H, 120: visible height in pixels
- SPRITE_W, 25: sprite width, odd; HALF = (SPRITE_W-1)/2 = 12
- SPRITE_H, 5: sprite height in rows
- SPRITE_Y, 78: top row of the sprite
- START_X, 80: sprite centre x after reset
- STEP, 1: pixels moved per frame
- BG_COLOUR, 3'b001: erase colour
- SPRITE_COLOUR, 3'b010: draw colour
- clock  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse from `limiter`
- move_left  in  1  level; sampled only on an accepted frame_tick
- move_right  in  1  level; sampled only on an accepted frame_tick
- x_out  out  8  pixel x to `vga_adapter`
- y_out  out  7  pixel y to `vga_adapter`
- colour_out  out  3  pixel colour
- plot  out  1  write strobe; x/y/colour are valid when high
- pos_x  out  8  current sprite centre x
- busy  out  1  high from ERASE or DRAW entry until DONE exits
- frame_done  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, ERASE, MOVE, DRAW, DONE. The `drawn` flag is cleared by reset.
- IDLE + frame_tick, `drawn`=0: skip erase and go to DRAW at pos_x; set `drawn` in DONE.
- IDLE + frame_tick, `drawn`=1: compute target position.
  - left only: target = max(pos_x-STEP, HALF)
  - right only: target = min(pos_x+STEP, SCREEN_W-1-HALF)
  - both or neither: target = pos_x
- If target == pos_x: go to DONE directly, with no plotting.
- If target != pos_x: go to ERASE.
- ERASE: fill the rectangle at the old pos_x with BG_COLOUR.
- MOVE: one cycle; pos_x <= target.
- DRAW: fill the rectangle at pos_x with SPRITE_COLOUR.
- DONE: one cycle; frame_done=1; return to IDLE.
- Rectangle definition: x in [pos_x-HALF, pos_x+HALF], y in [SPRITE_Y, SPRITE_Y+SPRITE_H-1].
- Fill order: raster, x fastest then y; N = SPRITE_W*SPRITE_H = 125 pixels.
- frame_tick outside IDLE is dropped; it is neither queued nor counted.
- Arithmetic is 8-bit unsigned and never wraps, guaranteed by the clamp.
- Parameter legality (elaboration-time check):
  - HALF <= START_X <= SCREEN_W-1-HALF
  - SPRITE_Y+SPRITE_H <= SCREEN_H
- Reset values: x_out=0, y_out=0, colour_out=0, plot=0, busy=0, frame_done=0, pos_x=START_X; state=IDLE.
- Reset asserted mid-fill forces plot=0 immediately. The partially drawn frame is left on screen, and the next tick performs a draw-only frame.

## Timing
All outputs are registered. Edge t is the edge on which frame_tick is sampled high in IDLE.
- Move frame:
  - erase pixels: plot=1 on edges t+2 .. t+N+1
  - pos_x updates: edge t+N+2
  - draw pixels: plot=1 on edges t+N+4 .. t+2N+3
  - frame_done: edge t+2N+4 (t+254)
  - next tick accepted from edge t+2N+5
- Draw-only frame: pixels t+2 .. t+N+1; frame_done at t+N+2.
- No-move frame: frame_done at t+1; busy stays 0; no plot.
- plot is contiguous within each fill, with no bubbles. plot is low in MOVE, DONE and IDLE.

## Structure
- Package `game_pkg` holds:
  - colour constants (BLACK, BLUE, GREEN, WHITE)
  - screen dimensions
  - the state enum for this block
- Sub-module `rect_filler` walks the rectangle.
  - Inputs: start pulse plus x0, y0, w, h, colour.
  - Outputs: registered x, y, colour, plot, and done.
  - done is asserted together with the last pixel.
  - First pixel appears one edge after start is sampled.
  - start while the filler is active is ignored.
- The scheduler owns the FSM, pos_x, `drawn` and the clamp logic, and muxes the filler outputs to the ports.

## Test plan
- Reset, tick with no buttons: 125 plots, colour 010, x 68..92, y 78..82, raster order; frame_done at t+127; pos_x=80.
- After initial draw, tick with move_right: 125 erase plots, colour 001, x 68..92; pos_x=81 at t+127; 125 draw plots, colour 010, x 69..93; frame_done at t+254.
- Clamp at right edge: pos_x=147 (reached by ticks with move_right), tick with move_right: pos_x stays 147, no plot, frame_done at t+1, busy=0. Mirror check with move_left at pos_x=12.
- Both buttons high on a tick: no plot, pos_x unchanged, frame_done at t+1.
- Second frame_tick at t+50 during a move frame: ignored; exactly 250 plots and one frame_done.
- Reset asserted at t+30 during ERASE: plot=0 asynchronously, pos_x=80, busy=0. The next tick produces a draw-only frame (125 plots, colour 010, x 68..92).

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared colours, screen geometry and sprite scheduler state enum
//
// Purpose: common definitions for the game datapath blocks.
//   - 3-bit colour constants used by the VGA adapter
//   - visible screen dimensions
//   - state enum of the sprite scheduler FSM
//   - clamp helper computing the next sprite centre from the move buttons
package game_pkg;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] BLUE  = 3'b001;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] WHITE = 3'b111;

   localparam int SCREEN_WIDTH  = 160;
   localparam int SCREEN_HEIGHT = 120;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_MOVE,
      S_DRAW,
      S_DONE
   } sched_state_t;

   // Next centre position for one frame. Both or neither button holds the
   // position. The comparisons are arranged so that no intermediate value
   // wraps in 8 bits (lo >= step and hi >= step for any legal setting).
   function automatic logic [7:0] next_target(
      input logic [7:0] pos,
      input logic       left,
      input logic       right,
      input logic [7:0] step,
      input logic [7:0] lo,
      input logic [7:0] hi
   );
      logic [7:0] t;
      t = pos;
      if (left && !right) begin
         t = (pos >= lo + step) ? pos - step : lo;
      end else if (right && !left) begin
         t = (pos <= hi - step) ? pos + step : hi;
      end
      return t;
   endfunction

endpackage

// File: rtl/sprite_scheduler_if.sv
// rtl/sprite_scheduler_if.sv - frame control and VGA write port bundle of the sprite scheduler
//
// Purpose: groups the scheduler's frame inputs, pixel write port and status.
// Signals:
//   frame_tick  one-cycle frame pulse from the rate limiter
//   move_left   button level, sampled on an accepted tick
//   move_right  button level, sampled on an accepted tick
//   x_out       pixel x to the VGA adapter (8 bits)
//   y_out       pixel y to the VGA adapter (7 bits)
//   colour_out  pixel colour (3 bits)
//   plot        write strobe, x/y/colour valid while high
//   pos_x       current sprite centre x
//   busy        a fill sequence is in progress
//   frame_done  one-cycle pulse at frame completion
// Modports: master = scheduler side, slave = limiter / adapter side.
interface sprite_scheduler_if;

   logic       frame_tick;
   logic       move_left;
   logic       move_right;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;
   logic       plot;
   logic [7:0] pos_x;
   logic       busy;
   logic       frame_done;

   modport master (
      input  frame_tick, move_left, move_right,
      output x_out, y_out, colour_out, plot, pos_x, busy, frame_done
   );

   modport slave (
      output frame_tick, move_left, move_right,
      input  x_out, y_out, colour_out, plot, pos_x, busy, frame_done
   );

endinterface

// File: rtl/rect_filler.sv
// rtl/rect_filler.sv - raster walker emitting one pixel write per cycle over a rectangle
//
// Purpose: on a start pulse, latches the rectangle and walks it x fastest,
// then y, producing one registered pixel per clock with no gaps.
// Ports:
//   clock, reset    system clock, asynchronous active-high reset
//   start           begin a fill; ignored while a fill is active
//   x0, y0          top-left corner
//   w, h            width and height in pixels (zero size is ignored)
//   colour          fill colour
//   pix_x, pix_y    registered pixel coordinates
//   pix_colour      registered pixel colour
//   plot            registered write strobe
//   done            registered, high together with the last pixel
//   ending          combinational, high in the cycle whose edge issues the
//                   last pixel; lets the controller chain the next step
//                   without losing a cycle
// Timing: start sampled on edge s gives pixels on edges s+1 .. s+w*h.
module rect_filler
   import game_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] x0,
   input  logic [6:0] y0,
   input  logic [7:0] w,
   input  logic [6:0] h,
   input  logic [2:0] colour,
   output logic [7:0] pix_x,
   output logic [6:0] pix_y,
   output logic [2:0] pix_colour,
   output logic       plot,
   output logic       done,
   output logic       ending
);

   logic       active;
   logic [7:0] cx;
   logic [6:0] cy;
   logic [7:0] lx0;
   logic [6:0] ly0;
   logic [7:0] lw;
   logic [6:0] lh;
   logic [2:0] lcol;
   logic       row_end;

   assign row_end = (cx == lw - 8'd1);
   assign ending  = active && row_end && (cy == lh - 7'd1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         active     <= 1'b0;
         cx         <= '0;
         cy         <= '0;
         lx0        <= '0;
         ly0        <= '0;
         lw         <= '0;
         lh         <= '0;
         lcol       <= BLACK;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_colour <= BLACK;
         plot       <= 1'b0;
         done       <= 1'b0;
      end else if (active) begin
         plot       <= 1'b1;
         pix_x      <= lx0 + cx;
         pix_y      <= ly0 + cy;
         pix_colour <= lcol;
         done       <= ending;
         if (row_end) begin
            cx <= '0;
            cy <= cy + 7'd1;
         end else begin
            cx <= cx + 8'd1;
         end
         if (ending) begin
            active <= 1'b0;
         end
      end else begin
         plot <= 1'b0;
         done <= 1'b0;
         if (start && (w != 8'd0) && (h != 7'd0)) begin
            active <= 1'b1;
            cx     <= '0;
            cy     <= '0;
            lx0    <= x0;
            ly0    <= y0;
            lw     <= w;
            lh     <= h;
            lcol   <= colour;
         end
      end
   end

endmodule

// File: rtl/sprite_scheduler.sv
// rtl/sprite_scheduler.sv - per-frame player sprite move, erase and redraw sequencer
//
// Purpose: on each accepted frame tick, reads the move buttons, clamps the new
// centre to the screen, erases the sprite at the old centre, moves, and
// redraws it, driving the VGA adapter write port from a rect_filler.
// Ports:
//   clock   system clock
//   reset   asynchronous, active-high
//   bus     sprite_scheduler_if.master (frame inputs, pixel port, status)
// Behaviour summary:
//   first frame after reset  draw only at pos_x
//   move frame               erase old, update pos_x, draw new
//   no-move frame            frame_done one edge after the tick, no plotting
//   frame_tick outside IDLE  dropped
module sprite_scheduler
   import game_pkg::*;
#(
   parameter int         SCREEN_W      = SCREEN_WIDTH,
   parameter int         SCREEN_H      = SCREEN_HEIGHT,
   parameter int         SPRITE_W      = 25,
   parameter int         SPRITE_H      = 5,
   parameter int         SPRITE_Y      = 78,
   parameter int         START_X       = 80,
   parameter int         STEP          = 1,
   parameter logic [2:0] BG_COLOUR     = BLUE,
   parameter logic [2:0] SPRITE_COLOUR = GREEN
) (
   input  logic                clock,
   input  logic                reset,
   sprite_scheduler_if.master  bus
);

   localparam int         HALF     = (SPRITE_W - 1) / 2;
   localparam logic [7:0] HALF_X   = 8'(HALF);
   localparam logic [7:0] MAX_X    = 8'(SCREEN_W - 1 - HALF);
   localparam logic [7:0] STEP_X   = 8'(STEP);
   localparam logic [7:0] START_X8 = 8'(START_X);
   localparam logic [7:0] RECT_W   = 8'(SPRITE_W);
   localparam logic [6:0] RECT_H   = 7'(SPRITE_H);
   localparam logic [6:0] RECT_Y   = 7'(SPRITE_Y);

   if ((SPRITE_W % 2) != 1) begin : g_bad_width
      $error("SPRITE_W must be odd");
   end
   if ((START_X < HALF) || (START_X > SCREEN_W - 1 - HALF)) begin : g_bad_start
      $error("START_X outside the clamp range");
   end
   if (SPRITE_Y + SPRITE_H > SCREEN_H) begin : g_bad_height
      $error("sprite extends below the screen");
   end

   sched_state_t state;
   logic [7:0]   pos_x_r;
   logic [7:0]   target;
   logic         drawn;
   logic         busy_r;
   logic         frame_done_r;
   logic         fill_start;
   logic [7:0]   fill_x0;
   logic [2:0]   fill_colour;
   logic [7:0]   next_pos;

   logic [7:0]   pix_x;
   logic [6:0]   pix_y;
   logic [2:0]   pix_colour;
   logic         pix_plot;
   logic         fill_done;
   logic         fill_ending;

   assign next_pos = next_target(pos_x_r, bus.move_left, bus.move_right,
                                 STEP_X, HALF_X, MAX_X);

   // fill_start is registered, so the filler samples it one edge after the
   // FSM raises it; leaving ERASE/DRAW on fill_ending (the edge issuing the
   // last pixel) keeps MOVE and DONE to exactly one cycle each.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         pos_x_r      <= START_X8;
         target       <= START_X8;
         drawn        <= 1'b0;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         fill_start   <= 1'b0;
         fill_x0      <= '0;
         fill_colour  <= BLACK;
      end else begin
         fill_start   <= 1'b0;
         frame_done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.frame_tick) begin
                  if (!drawn) begin
                     state       <= S_DRAW;
                     busy_r      <= 1'b1;
                     fill_start  <= 1'b1;
                     fill_x0     <= pos_x_r - HALF_X;
                     fill_colour <= SPRITE_COLOUR;
                  end else if (next_pos == pos_x_r) begin
                     state <= S_DONE;
                  end else begin
                     state       <= S_ERASE;
                     busy_r      <= 1'b1;
                     target      <= next_pos;
                     fill_start  <= 1'b1;
                     fill_x0     <= pos_x_r - HALF_X;
                     fill_colour <= BG_COLOUR;
                  end
               end
            end
            S_ERASE: begin
               if (fill_ending) begin
                  state <= S_MOVE;
               end
            end
            S_MOVE: begin
               pos_x_r     <= target;
               state       <= S_DRAW;
               fill_start  <= 1'b1;
               fill_x0     <= target - HALF_X;
               fill_colour <= SPRITE_COLOUR;
            end
            S_DRAW: begin
               if (fill_ending) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               frame_done_r <= 1'b1;
               busy_r       <= 1'b0;
               // After a draw the filler's done is still showing the last
               // pixel here; a no-move frame only happens once drawn is set.
               drawn        <= drawn | fill_done;
               state        <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   rect_filler u_filler (
      .clock      (clock),
      .reset      (reset),
      .start      (fill_start),
      .x0         (fill_x0),
      .y0         (RECT_Y),
      .w          (RECT_W),
      .h          (RECT_H),
      .colour     (fill_colour),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_colour (pix_colour),
      .plot       (pix_plot),
      .done       (fill_done),
      .ending     (fill_ending)
   );

   assign bus.x_out      = pix_x;
   assign bus.y_out      = pix_y;
   assign bus.colour_out = pix_colour;
   assign bus.plot       = pix_plot;
   assign bus.pos_x      = pos_x_r;
   assign bus.busy       = busy_r;
   assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_sprite_scheduler.sv
// tb/tb_sprite_scheduler.sv - self-checking bench for sprite_scheduler
module tb_sprite_scheduler;

   localparam int N  = 125;
   localparam int SW = 25;
   localparam int SY = 78;

   logic clock = 1'b0;
   logic reset;

   sprite_scheduler_if bus();

   sprite_scheduler dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // per-frame observations
   int n_erase, n_draw, n_other, rast_err;
   int first_e, last_e, first_d, last_d;
   int done_k, done_cnt, pos_k;
   int busy1, busy_pre, busy_done;

   typedef struct {
      logic left;
      logic right;
      int   retick;
      bit   erase;
      bit   draw;
      int   ex0;
      int   dx0;
      int   pos_after;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issues one tick (sampled on edge t) and observes edges t+1 onward.
   task automatic run_frame(input logic l, input logic r, input int retick,
                            input int ex0, input int dx0, input int exp_done);
      int prev_pos;
      n_erase = 0; n_draw = 0; n_other = 0; rast_err = 0;
      first_e = -1; last_e = -1; first_d = -1; last_d = -1;
      done_k = -1; done_cnt = 0; pos_k = -1;
      busy1 = -1; busy_pre = -1; busy_done = -1;
      prev_pos = int'(bus.pos_x);
      @(negedge clock);
      bus.frame_tick = 1'b1;
      bus.move_left  = l;
      bus.move_right = r;
      @(posedge clock);
      @(negedge clock);
      bus.frame_tick = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clock);
         if (bus.plot) begin
            if (bus.colour_out == 3'b001) begin
               if ((int'(bus.x_out) != ex0 + n_erase % SW) ||
                   (int'(bus.y_out) != SY + n_erase / SW)) rast_err++;
               if (first_e < 0) first_e = k;
               last_e = k;
               n_erase++;
            end else if (bus.colour_out == 3'b010) begin
               if ((int'(bus.x_out) != dx0 + n_draw % SW) ||
                   (int'(bus.y_out) != SY + n_draw / SW)) rast_err++;
               if (first_d < 0) first_d = k;
               last_d = k;
               n_draw++;
            end else begin
               n_other++;
            end
         end
         if (bus.frame_done) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         if (int'(bus.pos_x) != prev_pos) begin
            if (pos_k < 0) pos_k = k;
            prev_pos = int'(bus.pos_x);
         end
         if (k == 1) busy1 = int'(bus.busy);
         if (k == exp_done - 1) busy_pre = int'(bus.busy);
         if (k == exp_done) busy_done = int'(bus.busy);
         if (k == retick - 1) bus.frame_tick = 1'b1;
         if (k == retick) bus.frame_tick = 1'b0;
         if ((done_k > 0) && (k >= done_k + 3)) break;
      end
   endtask

   task automatic check_frame(input string tag, input logic l, input logic r,
                              input int retick, input bit e, input bit d,
                              input int ex0, input int dx0, input int pos_after);
      int exp_done;
      exp_done = e ? 2 * N + 4 : (d ? N + 2 : 1);
      run_frame(l, r, retick, ex0, dx0, exp_done);
      chk({tag, " erase_count"}, n_erase, e ? N : 0);
      chk({tag, " draw_count"}, n_draw, d ? N : 0);
      chk({tag, " other_colour"}, n_other, 0);
      chk({tag, " raster_order"}, rast_err, 0);
      chk({tag, " erase_first"}, first_e, e ? 2 : -1);
      chk({tag, " erase_last"}, last_e, e ? N + 1 : -1);
      chk({tag, " draw_first"}, first_d, d ? (e ? N + 4 : 2) : -1);
      chk({tag, " draw_last"}, last_d, d ? (e ? 2 * N + 3 : N + 1) : -1);
      chk({tag, " done_edge"}, done_k, exp_done);
      chk({tag, " done_count"}, done_cnt, 1);
      chk({tag, " pos_x"}, int'(bus.pos_x), pos_after);
      chk({tag, " pos_edge"}, pos_k, e ? N + 2 : -1);
      chk({tag, " busy_first"}, busy1, (e || d) ? 1 : 0);
      chk({tag, " busy_at_done"}, busy_done, 0);
      if (exp_done >= 2) chk({tag, " busy_before_done"}, busy_pre, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          left  right retick erase draw ex0 dx0 pos
      vecs[0] = '{1'b0, 1'b0, 0,  1'b0, 1'b1, 0,  68, 80};
      vecs[1] = '{1'b0, 1'b1, 0,  1'b1, 1'b1, 68, 69, 81};
      vecs[2] = '{1'b1, 1'b0, 0,  1'b1, 1'b1, 69, 68, 80};
      vecs[3] = '{1'b1, 1'b1, 0,  1'b0, 1'b0, 0,  0,  80};
      vecs[4] = '{1'b0, 1'b0, 0,  1'b0, 1'b0, 0,  0,  80};
      vecs[5] = '{1'b0, 1'b1, 50, 1'b1, 1'b1, 68, 69, 81};

      reset = 1'b1;
      bus.frame_tick = 1'b0;
      bus.move_left  = 1'b0;
      bus.move_right = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset x_out", int'(bus.x_out), 0);
      chk("reset y_out", int'(bus.y_out), 0);
      chk("reset colour_out", int'(bus.colour_out), 0);
      chk("reset plot", int'(bus.plot), 0);
      chk("reset busy", int'(bus.busy), 0);
      chk("reset frame_done", int'(bus.frame_done), 0);
      chk("reset pos_x", int'(bus.pos_x), 80);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 6; i++) begin
         check_frame($sformatf("v%0d", i), vecs[i].left, vecs[i].right,
                     vecs[i].retick, vecs[i].erase, vecs[i].draw,
                     vecs[i].ex0, vecs[i].dx0, vecs[i].pos_after);
      end

      // reset during the erase fill of a move frame (pos_x is 81 here)
      @(negedge clock);
      bus.frame_tick = 1'b1;
      bus.move_left  = 1'b0;
      bus.move_right = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.frame_tick = 1'b0;
      repeat (29) @(negedge clock);
      chk("midreset erasing", int'(bus.plot && bus.colour_out == 3'b001), 1);
      reset = 1'b1;
      #1;
      chk("midreset plot", int'(bus.plot), 0);
      chk("midreset pos_x", int'(bus.pos_x), 80);
      chk("midreset busy", int'(bus.busy), 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check_frame("after_reset", 1'b0, 1'b0, 0, 1'b0, 1'b1, 0, 68, 80);

      // walk to the right edge, then tick right against the clamp
      for (int p = 80; p < 147; p++) begin
         run_frame(1'b0, 1'b1, 0, p - 12, p - 11, 2 * N + 4);
      end
      chk("walk_right pos_x", int'(bus.pos_x), 147);
      check_frame("clamp_right", 1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 0, 147);

      // fresh start, walk to the left edge, tick left against the clamp
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_frame("redraw", 1'b0, 1'b0, 0, 1'b0, 1'b1, 0, 68, 80);
      for (int p = 80; p > 12; p--) begin
         run_frame(1'b1, 1'b0, 0, p - 12, p - 13, 2 * N + 4);
      end
      chk("walk_left pos_x", int'(bus.pos_x), 12);
      check_frame("clamp_left", 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
